fix_div: RTL and testbench

FIX_DIV -- requirements
Module: fix_div

---
 rtl/fix_div.sv | 131 +++++++++++++
 tb/tb_fix_div.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fix_div.sv
// Signed fixed-point divider: restoring division on magnitudes, one quotient bit per cycle.
// state | meaning: IDLE accept operands | CALC shift/subtract | SIGN apply sign or saturate | DONE hold result
module fix_div #(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   outQ,
  output logic                 div_zero
);

  localparam int N  = WIDTH + POINT_WIDTH;
  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]  div_q, div_d;
  logic            sign_q, sign_d;
  logic            zb_q, zb_d;
  logic [QW-1:0]   outq_q, outq_d;
  logic            dz_q, dz_d;

  logic [WIDTH:0]  sx_a, sx_b, mag_a, mag_b;
  logic [WIDTH:0]  rem_sh;
  logic            ge;
  logic [QW-1:0]   mag_ext;

  // WIDTH+1 bits so that -2^(WIDTH-1) has a representable magnitude
  assign sx_a   = {inA[WIDTH-1], inA};
  assign sx_b   = {inB[WIDTH-1], inB};
  assign mag_a  = inA[WIDTH-1] ? -sx_a : sx_a;
  assign mag_b  = inB[WIDTH-1] ? -sx_b : sx_b;
  assign rem_sh = {rem_q, dvd_q[N-1]};
  assign ge     = (rem_sh >= div_q);
  assign mag_ext = {{(QW-N){1'b0}}, dvd_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    sign_d  = sign_q;
    zb_d    = zb_q;
    outq_d  = outq_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d = '0;
          cnt_d = CW'(N);
          dvd_d = N'({mag_a, {POINT_WIDTH{1'b0}}});
          div_d = mag_b;
          if (inB == '0) begin
            zb_d    = 1'b1;
            sign_d  = inA[WIDTH-1];
            state_d = SIGN;
          end else begin
            zb_d    = 1'b0;
            sign_d  = inA[WIDTH-1] ^ inB[WIDTH-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // dividend register doubles as the quotient shift register
        if (cnt_q != '0) begin
          rem_d = ge ? WIDTH'(rem_sh - div_q) : rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[N-2:0], ge};
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        dz_d = zb_q;
        if (zb_q)
          outq_d = sign_q ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
        else
          outq_d = sign_q ? -mag_ext : mag_ext;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      sign_q  <= 1'b0;
      zb_q    <= 1'b0;
      outq_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      zb_q    <= zb_d;
      outq_q  <= outq_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign outQ      = outq_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_fix_div.sv
// Directed bench for fix_div: scoreboard of expected quotients, latency and handshake checks.
module tb_fix_div;
  localparam int W  = 16;
  localparam int P  = 8;
  localparam int N  = W + P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  inA = '0;
  logic [W-1:0]  inB = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] outQ;
  logic          div_zero;

  typedef struct {
    logic [2*W-1:0] q;
    logic           dz;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fix_div #(.WIDTH(W), .POINT_WIDTH(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready),
    .outQ(outQ), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_, q;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (sb_ == 0) return a[W-1] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
    q = (sa * (longint'(1) << P)) / sb_;
    return q[2*W-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    inA = a;
    inB = b;
    e.q   = model_q(a, b);
    e.dz  = (b == '0);
    e.lat = (b == '0) ? 1 : N + 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inA = W'($urandom);
    inB = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, e.lat);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      got = sb.pop_front();
      chk("outQ", outQ, got.q);
      chk("div_zero", div_zero, got.dz);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      inA = W'($urandom);
      inB = W'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      chk("hold_outQ", outQ, e.q);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_outQ", outQ, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0300, 16'h0200, 0);
    run_op(16'hFD00, 16'h0200, 2);
    run_op(16'h0100, 16'h0300, 0);
    run_op(16'h8000, 16'hFF00, 0);
    run_op(16'h0100, 16'h0000, 10);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h7FFF, 16'h8000, 0);
    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1);
    end
    run_op(16'hFF00, 16'h0000, 3);

    // abort an operation in its fifth CALC cycle
    @(negedge clk);
    in_valid = 1'b1;
    inA = 16'h0500;
    inB = 16'h0300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_div_zero", div_zero, 0);
    chk("abort_outQ", outQ, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no_stale_valid", seen, 0);
    run_op(16'h0300, 16'h0200, 0);
    run_op(16'hFD00, 16'h0200, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
